// File: rtl/prio_arbiter_if.sv
// ---------------------------------------------------------------------------
// prio_arbiter_if
// Bundles the request/grant signals exchanged between a set of requesters
// and the prio_arbiter block.
//
// Parameters
//   N   number of requesters
//   IW  width of the binary grant index
//
// Signals
//   req      [N-1:0]  request lines, bit i belongs to requester i
//   rel               release strobe from the current owner
//   gnt      [N-1:0]  one-hot grant, zero when idle
//   gnt_idx  [IW-1:0] binary index of the granted requester, zero when idle
//   gnt_vld           high whenever gnt is non-zero
//   tmo               one-cycle pulse marking a forced release at HOLD_MAX
//
// Modports
//   master  requester side (drives req/rel, observes the grant)
//   slave   arbiter side (observes req/rel, drives the grant)
// ---------------------------------------------------------------------------
interface prio_arbiter_if #(
   parameter int N  = 4,
   parameter int IW = 2
);
   logic [N-1:0]  req;
   logic          rel;
   logic [N-1:0]  gnt;
   logic [IW-1:0] gnt_idx;
   logic          gnt_vld;
   logic          tmo;

   modport master (
      output req,
      output rel,
      input  gnt,
      input  gnt_idx,
      input  gnt_vld,
      input  tmo
   );

   modport slave (
      input  req,
      input  rel,
      output gnt,
      output gnt_idx,
      output gnt_vld,
      output tmo
   );
endinterface

// File: rtl/prio_arbiter.sv
// ---------------------------------------------------------------------------
// prio_arbiter
// N-way arbiter with bounded ownership. One requester owns the grant until
// it releases (rel), drops its request, or has held the grant for HOLD_MAX
// consecutive cycles. Every ownership ends with exactly one dead cycle (GAP)
// before the next arbitration.
//
// Parameters
//   N         number of requesters (2..16)
//   IW        grant index width, ceil(log2(N))
//   HOLD_MAX  maximum consecutive grant cycles per ownership (1..255)
//
// Ports
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      prio_arbiter_if.slave: req/rel in, gnt/gnt_idx/gnt_vld/tmo out
//
// Compile-time option
//   PRIO_ARBITER_RR_EN  when defined, arbitration is round-robin descending
//                       (after granting k, the search starts at k-1 and
//                       wraps from 0 to N-1). When undefined, the highest
//                       numbered active request always wins and no priority
//                       pointer is built.
// ---------------------------------------------------------------------------
module prio_arbiter #(
   parameter int N        = 4,
   parameter int IW       = 2,
   parameter int HOLD_MAX = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   prio_arbiter_if.slave bus
);

   // Counter only needs to reach HOLD_MAX; exit happens on equality so it
   // never wraps.
   localparam int CW = $clog2(HOLD_MAX + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GRANT = 2'd1;
   localparam logic [1:0] GAP   = 2'd2;

   localparam logic [N-1:0]  ONE      = N'(1);
   localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);

   logic [1:0]    state;
   logic [N-1:0]  gnt_q;
   logic [IW-1:0] idx_q;
   logic          vld_q;
   logic          tmo_q;
   logic [CW-1:0] hold_cnt;

   logic [N-1:0]  req_s;
   logic          rel_s;

   logic [IW-1:0] sel_idx;
   logic          sel_vld;
   logic          grant_issue;
   logic          owner_req;
   logic          hold_hit;
   logic          grant_exit;
   logic          timeout;

   assign req_s = bus.req;
   assign rel_s = bus.rel;

   assign bus.gnt     = gnt_q;
   assign bus.gnt_idx = idx_q;
   assign bus.gnt_vld = vld_q;
   assign bus.tmo     = tmo_q;

`ifdef PRIO_ARBITER_RR_EN
   // Priority pointer: the requester searched first. It points just below
   // the last winner so the last winner becomes the lowest priority.
   logic [IW-1:0] ptr;

   // Descending search starting at ptr with wrap from 0 to N-1. The loop
   // walks from the far end towards ptr so the candidate closest to ptr
   // overwrites the others and wins.
   always_comb begin
      int            cand;
      logic [IW-1:0] cidx;
      sel_idx = '0;
      sel_vld = 1'b0;
      cand    = 0;
      cidx    = '0;
      for (int off = N - 1; off >= 0; off--) begin
         cand = int'(ptr) - off;
         if (cand < 0) begin
            cand = cand + N;
         end
         cidx = IW'(cand);
         if (req_s[cidx]) begin
            sel_idx = cidx;
            sel_vld = 1'b1;
         end
      end
   end

   // The pointer only moves when a new ownership actually begins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr <= IW'(N - 1);
      end else if (grant_issue) begin
         ptr <= (sel_idx == '0) ? IW'(N - 1) : sel_idx - IW'(1);
      end
   end
`else
   // Fixed priority: ascending scan so the highest set bit is the last
   // one written and therefore wins.
   always_comb begin
      sel_idx = '0;
      sel_vld = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (req_s[IW'(i)]) begin
            sel_idx = IW'(i);
            sel_vld = 1'b1;
         end
      end
   end
`endif

   // GAP arbitrates exactly like IDLE; the dead cycle comes from GRANT
   // always passing through GAP, not from GAP itself waiting.
   assign grant_issue = (state != GRANT) && sel_vld;

   assign owner_req  = req_s[idx_q];
   assign hold_hit   = (hold_cnt == HOLD_LIM);
   assign grant_exit = rel_s || !owner_req || hold_hit;

   // A release or a dropped request takes precedence over the timeout, so
   // tmo only flags an exit caused by the hold limit alone.
   assign timeout = hold_hit && !rel_s && owner_req;

   // Main control: state, registered grant outputs and the hold counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         gnt_q    <= '0;
         idx_q    <= '0;
         vld_q    <= 1'b0;
         tmo_q    <= 1'b0;
         hold_cnt <= '0;
      end else begin
         tmo_q <= 1'b0;
         case (state)
            IDLE, GAP: begin
               if (sel_vld) begin
                  state    <= GRANT;
                  gnt_q    <= ONE << sel_idx;
                  idx_q    <= sel_idx;
                  vld_q    <= 1'b1;
                  hold_cnt <= CW'(1);
               end else begin
                  state    <= IDLE;
                  gnt_q    <= '0;
                  idx_q    <= '0;
                  vld_q    <= 1'b0;
                  hold_cnt <= '0;
               end
            end
            GRANT: begin
               if (grant_exit) begin
                  state    <= GAP;
                  gnt_q    <= '0;
                  idx_q    <= '0;
                  vld_q    <= 1'b0;
                  hold_cnt <= '0;
                  tmo_q    <= timeout;
               end else begin
                  hold_cnt <= hold_cnt + CW'(1);
               end
            end
            default: begin
               state    <= IDLE;
               gnt_q    <= '0;
               idx_q    <= '0;
               vld_q    <= 1'b0;
               hold_cnt <= '0;
            end
         endcase
      end
   end

   // Structural invariants of the grant outputs.
   a_gnt_onehot: assert property (@(posedge clk) disable iff (!reset_n)
      $onehot0(gnt_q));

   a_vld_matches: assert property (@(posedge clk) disable iff (!reset_n)
      vld_q == (gnt_q != '0));

   a_idx_encodes: assert property (@(posedge clk) disable iff (!reset_n)
      gnt_q == (vld_q ? (ONE << idx_q) : '0));

   a_hold_bounded: assert property (@(posedge clk) disable iff (!reset_n)
      hold_cnt <= HOLD_LIM);

   a_tmo_in_gap: assert property (@(posedge clk) disable iff (!reset_n)
      tmo_q |-> (state == GAP));

endmodule

// File: tb/tb_prio_arbiter.sv
// ---------------------------------------------------------------------------
// tb_prio_arbiter
// Self-checking bench for prio_arbiter with N=4, HOLD_MAX=4. Each scenario
// task drives req/rel at the falling edge, pushes the expected
// {gnt, gnt_idx, gnt_vld, tmo} word into a scoreboard queue and pops it
// one unit after the following rising edge to compare with the DUT.
// Works in both the default (fixed priority) and PRIO_ARBITER_RR_EN builds.
// ---------------------------------------------------------------------------
module tb_prio_arbiter;

   localparam int N        = 4;
   localparam int IW       = 2;
   localparam int HOLD_MAX = 4;

   // Expected words: {gnt[3:0], gnt_idx[1:0], gnt_vld, tmo}
   localparam logic [7:0] Z   = 8'b0000_00_0_0;
   localparam logic [7:0] TMO = 8'b0000_00_0_1;
   localparam logic [7:0] G1  = 8'b0010_01_1_0;
   localparam logic [7:0] G2  = 8'b0100_10_1_0;
   localparam logic [7:0] G3  = 8'b1000_11_1_0;

`ifdef PRIO_ARBITER_RR_EN
   localparam logic [7:0] REGRANT_0110 = G1;
`else
   localparam logic [7:0] REGRANT_0110 = G2;
`endif

   logic clk     = 1'b0;
   logic reset_n = 1'b1;

   int compared   = 0;
   int mismatched = 0;

   logic [7:0] sb[$];

   prio_arbiter_if #(.N(N), .IW(IW)) bus();

   prio_arbiter #(
      .N(N),
      .IW(IW),
      .HOLD_MAX(HOLD_MAX)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   // Highest set bit of a request pattern, as seen right after reset.
   function automatic logic [7:0] first_grant(logic [3:0] p);
      for (int i = 3; i >= 0; i--) begin
         if (p[i]) begin
            return {4'b0001 << i, 2'(i), 1'b1, 1'b0};
         end
      end
      return Z;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      bus.req = '0;
      bus.rel = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [7:0] exp, got;
      #2;
      reset_n = 1'b0;
      sb.push_back(Z);
      #1;
      exp = sb.pop_front();
      got = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL reset_immediate: got %b want %b", got, exp);
      end
      @(negedge clk);
      bus.req = 4'b1111;
      sb.push_back(Z);
      @(posedge clk); #1;
      exp = sb.pop_front();
      got = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL reset_clocked: got %b want %b", got, exp);
      end
      @(negedge clk);
      reset_n = 1'b1;
      bus.req = 4'b0110;
      sb.push_back(G2);
      @(posedge clk); #1;
      exp = sb.pop_front();
      got = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL reset_first_edge: got %b want %b", got, exp);
      end
      @(negedge clk);
      bus.req = 4'b0000;
      sb.push_back(Z);
      @(posedge clk); #1;
      exp = sb.pop_front();
      got = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL reset_drop: got %b want %b", got, exp);
      end
      @(negedge clk);
   endtask

   task automatic test_release();
      logic [12:0] tbl[$];
      logic [7:0]  exp, got;
      do_reset();
      tbl.push_back({4'b0110, 1'b0, G2});
      tbl.push_back({4'b0110, 1'b0, G2});
      tbl.push_back({4'b0110, 1'b1, Z});
      tbl.push_back({4'b0110, 1'b0, REGRANT_0110});
      tbl.push_back({4'b0000, 1'b0, Z});
      tbl.push_back({4'b0000, 1'b0, Z});
      foreach (tbl[k]) begin
         bus.req = tbl[k][12:9];
         bus.rel = tbl[k][8];
         sb.push_back(tbl[k][7:0]);
         @(posedge clk); #1;
         exp = sb.pop_front();
         got = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
         compared++;
         if (got !== exp) begin
            mismatched++;
            $display("FAIL release[%0d]: got %b want %b", k, got, exp);
         end
         @(negedge clk);
      end
      bus.rel = 1'b0;
   endtask

   task automatic test_timeout();
      logic [12:0] tbl[$];
      logic [7:0]  exp, got;
      do_reset();
      repeat (HOLD_MAX) tbl.push_back({4'b1000, 1'b0, G3});
      tbl.push_back({4'b1000, 1'b0, TMO});
      tbl.push_back({4'b1000, 1'b0, G3});
      tbl.push_back({4'b0000, 1'b0, Z});
      tbl.push_back({4'b0000, 1'b0, Z});
      foreach (tbl[k]) begin
         bus.req = tbl[k][12:9];
         bus.rel = tbl[k][8];
         sb.push_back(tbl[k][7:0]);
         @(posedge clk); #1;
         exp = sb.pop_front();
         got = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
         compared++;
         if (got !== exp) begin
            mismatched++;
            $display("FAIL timeout[%0d]: got %b want %b", k, got, exp);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_rel_at_timeout();
      logic [12:0] tbl[$];
      logic [7:0]  exp, got;
      do_reset();
      repeat (HOLD_MAX) tbl.push_back({4'b1000, 1'b0, G3});
      tbl.push_back({4'b1000, 1'b1, Z});
      tbl.push_back({4'b1000, 1'b0, G3});
      tbl.push_back({4'b0000, 1'b0, Z});
      tbl.push_back({4'b0000, 1'b0, Z});
      foreach (tbl[k]) begin
         bus.req = tbl[k][12:9];
         bus.rel = tbl[k][8];
         sb.push_back(tbl[k][7:0]);
         @(posedge clk); #1;
         exp = sb.pop_front();
         got = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
         compared++;
         if (got !== exp) begin
            mismatched++;
            $display("FAIL rel_at_timeout[%0d]: got %b want %b", k, got, exp);
         end
         @(negedge clk);
      end
      bus.rel = 1'b0;
   endtask

   task automatic test_owner_hold();
      logic [12:0] tbl[$];
      logic [7:0]  exp, got;
      do_reset();
      tbl.push_back({4'b0010, 1'b0, G1});
      tbl.push_back({4'b1011, 1'b0, G1});
      tbl.push_back({4'b1111, 1'b0, G1});
      tbl.push_back({4'b1001, 1'b0, Z});
      tbl.push_back({4'b1000, 1'b0, G3});
      tbl.push_back({4'b0000, 1'b0, Z});
      tbl.push_back({4'b0000, 1'b0, Z});
      foreach (tbl[k]) begin
         bus.req = tbl[k][12:9];
         bus.rel = tbl[k][8];
         sb.push_back(tbl[k][7:0]);
         @(posedge clk); #1;
         exp = sb.pop_front();
         got = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
         compared++;
         if (got !== exp) begin
            mismatched++;
            $display("FAIL owner_hold[%0d]: got %b want %b", k, got, exp);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      logic [12:0] tbl[$];
      logic [7:0]  exp, got;
      int          order[5];
`ifdef PRIO_ARBITER_RR_EN
      order = '{3, 2, 1, 0, 3};
`else
      order = '{3, 3, 3, 3, 3};
`endif
      do_reset();
      for (int g = 0; g < 5; g++) begin
         tbl.push_back({4'b1111, 1'b0, 4'b0001 << order[g], 2'(order[g]), 1'b1, 1'b0});
         tbl.push_back({4'b1111, 1'b1, Z});
      end
      tbl.push_back({4'b0000, 1'b0, Z});
      foreach (tbl[k]) begin
         bus.req = tbl[k][12:9];
         bus.rel = tbl[k][8];
         sb.push_back(tbl[k][7:0]);
         @(posedge clk); #1;
         exp = sb.pop_front();
         got = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
         compared++;
         if (got !== exp) begin
            mismatched++;
            $display("FAIL back_to_back[%0d]: got %b want %b", k, got, exp);
         end
         @(negedge clk);
      end
      bus.rel = 1'b0;
   endtask

   task automatic test_patterns();
      logic [3:0] pats[$];
      logic [7:0] exp, got;
      pats = '{4'b0000, 4'b0001, 4'b0011, 4'b0101, 4'b1010, 4'b1100, 4'b0111};
      repeat (4) pats.push_back(4'($urandom_range(0, 15)));
      foreach (pats[k]) begin
         do_reset();
         bus.req = pats[k];
         sb.push_back(first_grant(pats[k]));
         @(posedge clk); #1;
         exp = sb.pop_front();
         got = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
         compared++;
         if (got !== exp) begin
            mismatched++;
            $display("FAIL pattern %b: got %b want %b", pats[k], got, exp);
         end
         @(negedge clk);
         bus.req = 4'b0000;
         sb.push_back(Z);
         @(posedge clk); #1;
         exp = sb.pop_front();
         got = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
         compared++;
         if (got !== exp) begin
            mismatched++;
            $display("FAIL pattern_drop %b: got %b want %b", pats[k], got, exp);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_async_reset();
      logic [7:0] exp, got;
      do_reset();
      bus.req = 4'b1000;
      for (int c = 0; c < HOLD_MAX; c++) begin
         sb.push_back(G3);
         @(posedge clk); #1;
         exp = sb.pop_front();
         got = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
         compared++;
         if (got !== exp) begin
            mismatched++;
            $display("FAIL async_pre[%0d]: got %b want %b", c, got, exp);
         end
         @(negedge clk);
      end
      // Owner is on its last allowed cycle; reset lands between edges.
      #2;
      reset_n = 1'b0;
      sb.push_back(Z);
      #1;
      exp = sb.pop_front();
      got = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL async_drop: got %b want %b", got, exp);
      end
      sb.push_back(Z);
      @(posedge clk); #1;
      exp = sb.pop_front();
      got = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL async_no_tmo: got %b want %b", got, exp);
      end
      @(negedge clk);
      reset_n = 1'b1;
      sb.push_back(G3);
      @(posedge clk); #1;
      exp = sb.pop_front();
      got = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL async_regrant: got %b want %b", got, exp);
      end
      @(negedge clk);
      bus.req = 4'b0000;
      sb.push_back(Z);
      @(posedge clk); #1;
      exp = sb.pop_front();
      got = {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.tmo};
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL async_end: got %b want %b", got, exp);
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.req = '0;
      bus.rel = 1'b0;
      $display("[TB] starting prio_arbiter bench");
      test_reset();
      test_release();
      test_timeout();
      test_rel_at_timeout();
      test_owner_hold();
      test_back_to_back();
      test_patterns();
      test_async_reset();
      if (sb.size() != 0) begin
         mismatched++;
         $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/prio_arbiter.md
PRIO_ARBITER -- requirements
Module: prio_arbiter

Interface
- REQ-001: Parameter N, default 4: number of requesters (2..16).
- REQ-002: Parameter IW, default 2: index width, equal to ceil(log2(N)).
- REQ-003: Parameter HOLD_MAX, default 16: maximum consecutive grant cycles per ownership (1..255).
- REQ-004: clk  input  1: single clock; all state updates on its rising edge.
- REQ-005: reset_n  input  1: asynchronous, active-low reset.
- REQ-006: req  input  N: request lines; bit i is requester i.
- REQ-007: rel  input  1: owner release strobe, sampled only while a grant is active.
- REQ-008: gnt  output  N: registered one-hot grant; all zeros when idle.
- REQ-009: gnt_idx  output  IW: registered binary index of the granted requester; 0 when idle.
- REQ-010: gnt_vld  output  1: registered; high exactly when gnt is non-zero.
- REQ-011: tmo  output  1: registered one-cycle pulse marking a forced release at HOLD_MAX.

Function
- REQ-012: FSM states SHALL be IDLE, GRANT and GAP.
- REQ-013: In IDLE with req non-zero, the block SHALL select one requester and enter GRANT, asserting gnt, gnt_idx and gnt_vld on the next rising edge (1-cycle latency).
- REQ-014: In IDLE with req zero, the block SHALL stay in IDLE with all grant outputs low.
- REQ-015: In fixed-priority mode, the highest-numbered asserted req bit SHALL win (req[N-1] highest, req[0] lowest).
- REQ-016: In GRANT, the owner SHALL be held unchanged regardless of other req activity.
- REQ-017: In GRANT, the hold counter SHALL start at 1 on the first grant cycle and increment each further grant cycle.
- REQ-018: GRANT SHALL exit to GAP when rel=1, when req[owner]=0, or when the hold counter equals HOLD_MAX.
- REQ-019: Grant outputs SHALL go low on the edge that enters GAP.
- REQ-020: tmo SHALL pulse for the GAP cycle only when the exit was caused solely by HOLD_MAX, with rel=0 and req[owner]=1.
- REQ-021: GAP SHALL last exactly one cycle with gnt=0, then behave as IDLE (arbitrate on the following edge); back-to-back grants are therefore separated by one dead cycle.
- REQ-022: Simultaneous rel and timeout SHALL be treated as a release (tmo=0).
- REQ-023: gnt SHALL always be one-hot or zero, and gnt_idx SHALL always encode gnt.
- REQ-024: The hold counter SHALL be wide enough for HOLD_MAX and SHALL never wrap.

Reset
- REQ-025: While reset_n=0, the block SHALL immediately force state=IDLE, gnt=0, gnt_idx=0, gnt_vld=0, tmo=0, hold counter=0 and priority pointer=N-1, regardless of clk.
- REQ-026: Reset asserted mid-grant SHALL drop the grant asynchronously, without a tmo pulse.
- REQ-027: The first arbitration SHALL occur on the first rising edge after reset_n deasserts.

Configuration
- REQ-028: Macro PRIO_ARBITER_RR_EN SHALL select the arbitration policy at compile time.
- REQ-029: With PRIO_ARBITER_RR_EN defined, the search SHALL be round-robin descending: after granting requester k, priority starts at k-1 and wraps from 0 to N-1, so k is lowest.
- REQ-030: With PRIO_ARBITER_RR_EN defined, the pointer SHALL update only when a grant is issued.
- REQ-031: Without PRIO_ARBITER_RR_EN, the policy SHALL be the fixed priority of REQ-015, and no pointer register SHALL be present.

Verification (N=4, HOLD_MAX=4)
- REQ-032: Reset then req=4'b0110 held, rel=0 -> one cycle later gnt=4'b0100, gnt_idx=2, gnt_vld=1.
- REQ-033: Owner 2 granted, rel pulsed at grant cycle 2 -> gnt=0 for one GAP cycle, tmo=0, then re-arbitration.
- REQ-034: req=4'b1000 held, rel=0 -> gnt_vld high exactly 4 cycles, then GAP with tmo=1 for 1 cycle, then gnt=4'b1000 again in fixed mode.
- REQ-035: RR build with req=4'b1111 held and rel pulsed each grant -> grant order 3,2,1,0,3, each separated by one GAP cycle.
- REQ-036: Owner 1 granted, req[1] dropped while req[3] rises -> GAP, then gnt=4'b1000; owner never changes during GRANT.
- REQ-037: reset_n driven low mid-grant between clock edges -> gnt, gnt_vld and gnt_idx go to 0 immediately, tmo stays 0.
